// File: rtl/ddr3_lif_arb_if.sv
// Local-interface bundle between the two requesters, the arbiter and the
// DDR3 x16 controller user port. The arbiter uses the slave view; the
// requester/controller environment uses the master view.
interface ddr3_lif_arb_if;
  // requester 0 (PCIe TLP engine)
  logic        req0_valid;
  logic [3:0]  req0_cmd;
  logic [25:0] req0_addr;
  logic [4:0]  req0_burst;
  logic        req0_ready;
  logic [63:0] req0_wdata;
  logic [7:0]  req0_wmask;
  logic        req0_wrdy;
  logic        req0_rvalid;
  // requester 1 (GPIO / test pattern engine)
  logic        req1_valid;
  logic [3:0]  req1_cmd;
  logic [25:0] req1_addr;
  logic [4:0]  req1_burst;
  logic        req1_ready;
  logic [63:0] req1_wdata;
  logic [7:0]  req1_wmask;
  logic        req1_wrdy;
  logic        req1_rvalid;
  // shared status
  logic [63:0] rdata;
  logic        busy;
  logic        err;
  // controller local port
  logic        init_start;
  logic        init_done;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic [25:0] addr;
  logic [4:0]  burst_cnt;
  logic        cmd_rdy;
  logic [63:0] write_data;
  logic [7:0]  data_mask;
  logic        datain_rdy;
  logic [63:0] read_data;
  logic        read_data_valid;

  modport slave (
    input  req0_valid, req0_cmd, req0_addr, req0_burst, req0_wdata, req0_wmask,
    input  req1_valid, req1_cmd, req1_addr, req1_burst, req1_wdata, req1_wmask,
    output req0_ready, req0_wrdy, req0_rvalid,
    output req1_ready, req1_wrdy, req1_rvalid,
    output rdata, busy, err,
    output init_start, cmd, cmd_valid, addr, burst_cnt, write_data, data_mask,
    input  init_done, cmd_rdy, datain_rdy, read_data, read_data_valid
  );

  modport master (
    output req0_valid, req0_cmd, req0_addr, req0_burst, req0_wdata, req0_wmask,
    output req1_valid, req1_cmd, req1_addr, req1_burst, req1_wdata, req1_wmask,
    input  req0_ready, req0_wrdy, req0_rvalid,
    input  req1_ready, req1_wrdy, req1_rvalid,
    input  rdata, busy, err,
    input  init_start, cmd, cmd_valid, addr, burst_cnt, write_data, data_mask,
    output init_done, cmd_rdy, datain_rdy, read_data, read_data_valid
  );
endinterface

// File: rtl/ddr3_lif_arb.sv
// Two-requester round-robin arbiter / sequencer for the DDR3 x16 controller
// local interface. Runs the init handshake after reset, issues one command at
// a time and steers write/read data beats to the requester that owns it.
// Optional data-phase watchdog: define DDR3_LIF_ARB_TIMEOUT_EN.
module ddr3_lif_arb #(
  parameter int INIT_DELAY = 16,
  parameter int TIMEOUT    = 4096
) (
  input logic           clk,
  input logic           rst,
  ddr3_lif_arb_if.slave bus
);
  localparam int DW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY + 1) : 1;

  typedef enum logic [2:0] {
    RST_WAIT, INIT, IDLE, CMD, WDATA, RDATA
  } state_t;

  state_t      r_state;
  logic [DW-1:0] r_dly;
  logic        r_init_start;
  logic        r_prio;      // requester that wins a tie
  logic        r_owner;     // requester owning the current command
  logic        r_cmd_valid;
  logic        r_busy;
  logic        r_err;
  logic [3:0]  r_cmd;
  logic [25:0] r_addr;
  logic [4:0]  r_burst;
  logic [5:0]  r_beats;     // holds up to 32
  logic [63:0] r_rdata;
  logic [1:0]  r_ready;
  logic [1:0]  r_rvalid;

  logic w_any, w_gnt1, w_is_wr, w_is_rd, w_in_wd, w_active, w_to_hit;

  assign w_any    = bus.req0_valid | bus.req1_valid;
  // requester 1 wins if it is alone or holds the priority pointer
  assign w_gnt1   = bus.req1_valid & (~bus.req0_valid | r_prio);
  assign w_is_wr  = (r_cmd == 4'b0010) || (r_cmd == 4'b0100);
  assign w_is_rd  = (r_cmd == 4'b0001) || (r_cmd == 4'b0011);
  assign w_in_wd  = (r_state == WDATA);
  assign w_active = (r_state == CMD) || (r_state == WDATA) || (r_state == RDATA);

`ifdef DDR3_LIF_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to;
  logic          w_hs;

  assign w_hs = ((r_state == CMD)   && bus.cmd_rdy) ||
                ((r_state == WDATA) && bus.datain_rdy) ||
                ((r_state == RDATA) && bus.read_data_valid);
  assign w_to_hit = w_active && !w_hs && (r_to == TW'(TIMEOUT - 1));

  // Watchdog: counts stalled cycles in the command/data phases, restarts on any handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_to <= '0;
    else if (w_active && !w_hs && !w_to_hit) r_to <= r_to + 1'b1;
    else                               r_to <= '0;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0) & w_active;
  assign w_to_hit = 1'b0;
`endif

  // Main sequencer: init handshake, grant, command issue and beat counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RST_WAIT;
      r_dly        <= '0;
      r_init_start <= 1'b0;
      r_prio       <= 1'b0;
      r_owner      <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_burst      <= '0;
      r_beats      <= '0;
      r_rdata      <= '0;
      r_ready      <= '0;
      r_rvalid     <= '0;
    end else begin
      r_ready  <= 2'b00;
      r_rvalid <= 2'b00;
      r_err    <= 1'b0;
      r_busy   <= 1'b1;
      case (r_state)
        RST_WAIT: begin
          if (r_dly == DW'(INIT_DELAY - 1)) begin
            r_dly        <= '0;
            r_init_start <= 1'b1;
            r_state      <= INIT;
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        INIT: begin
          if (bus.init_done) begin
            r_init_start <= 1'b0;
            r_state      <= IDLE;
            r_busy       <= 1'b0;
          end
        end
        IDLE: begin
          if (w_any) begin
            r_owner     <= w_gnt1;
            r_cmd       <= w_gnt1 ? bus.req1_cmd   : bus.req0_cmd;
            r_addr      <= w_gnt1 ? bus.req1_addr  : bus.req0_addr;
            r_burst     <= w_gnt1 ? bus.req1_burst : bus.req0_burst;
            r_cmd_valid <= 1'b1;
            r_state     <= CMD;
          end else begin
            r_busy <= 1'b0;
          end
        end
        CMD: begin
          if (r_cmd_valid && bus.cmd_rdy) begin
            r_cmd_valid      <= 1'b0;
            r_ready[r_owner] <= 1'b1;
            r_prio           <= ~r_owner;
            r_beats          <= (r_burst == 5'd0) ? 6'd32 : {1'b0, r_burst};
            if (w_is_wr)      r_state <= WDATA;
            else if (w_is_rd) r_state <= RDATA;
            else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        WDATA: begin
          if (bus.datain_rdy) begin
            r_beats <= r_beats - 1'b1;
            if (r_beats == 6'd1) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        RDATA: begin
          if (bus.read_data_valid) begin
            r_rdata           <= bus.read_data;
            r_rvalid[r_owner] <= 1'b1;
            r_beats           <= r_beats - 1'b1;
            if (r_beats == 6'd1) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= RST_WAIT;
      endcase
      // stalled phase gives up; pointer still moves on so the other side gets a turn
      if (w_to_hit) begin
        r_cmd_valid <= 1'b0;
        r_err       <= 1'b1;
        r_prio      <= ~r_owner;
        r_state     <= IDLE;
        r_busy      <= 1'b0;
      end
    end
  end

  assign bus.init_start  = r_init_start;
  assign bus.cmd         = r_cmd;
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.addr        = r_addr;
  assign bus.burst_cnt   = r_burst;
  assign bus.busy        = r_busy;
  assign bus.err         = r_err;
  assign bus.rdata       = r_rdata;
  assign bus.req0_ready  = r_ready[0];
  assign bus.req1_ready  = r_ready[1];
  assign bus.req0_rvalid = r_rvalid[0];
  assign bus.req1_rvalid = r_rvalid[1];

  // write path is only live during the write data phase so idle/reset drive zeros
  assign bus.write_data  = w_in_wd ? (r_owner ? bus.req1_wdata : bus.req0_wdata) : 64'd0;
  assign bus.data_mask   = w_in_wd ? (r_owner ? bus.req1_wmask : bus.req0_wmask) : 8'd0;
  assign bus.req0_wrdy   = w_in_wd & ~r_owner & bus.datain_rdy;
  assign bus.req1_wrdy   = w_in_wd &  r_owner & bus.datain_rdy;
endmodule
